conv2x2_sequencer: RTL

Controller and shared-MAC engine for the 2x2 convolution tile. It accepts a byte-command stream that loads the 4-byte input window and the 4-byte weight window. It sequences one 8x8 multiplier over the four taps and tracks the running maximum result. Results and the maximum are returned as two 9-bit beats on a valid/ready output that feeds the pin-level output mux.

---
 rtl/conv2x2_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/conv2x2_sequencer.sv
// conv2x2_sequencer: byte-command controller and shared-multiplier MAC engine
// for a 2x2 convolution tile. It loads input/weight windows, runs four taps
// through one multiplier, tracks the running maximum and returns each 18-bit
// value as two 9-bit beats on a valid/ready port.
module conv2x2_sequencer #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4,
    parameter int ACC_W  = 2 * DATA_W + 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_cmd,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                clear_max,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W/2:0]    out_data,
    output logic                busy
);

    localparam int HALF_W = ACC_W / 2;
    localparam int TAP_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PROD_W = 2 * DATA_W;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_MAC    = 3'd1;
    localparam logic [2:0] ST_UPDATE = 3'd2;
    localparam logic [2:0] ST_OUT0   = 3'd3;
    localparam logic [2:0] ST_OUT1   = 3'd4;

    localparam logic [1:0] CMD_LOAD_IN  = 2'b00;
    localparam logic [1:0] CMD_LOAD_W   = 2'b01;
    localparam logic [1:0] CMD_COMPUTE  = 2'b10;
    localparam logic [1:0] CMD_EMIT_MAX = 2'b11;

    logic [2:0]                    state_q,     state_d;
    logic [TAP_W-1:0]              tap_q,       tap_d;
    logic [ACC_W-1:0]              acc_q,       acc_d;
    logic [ACC_W-1:0]              result_q,    result_d;
    logic [ACC_W-1:0]              max_q,       max_d;
    logic [TAPS-1:0][DATA_W-1:0]   in_win_q,    in_win_d;
    logic [TAPS-1:0][DATA_W-1:0]   w_win_q,     w_win_d;
    logic                          out_valid_q, out_valid_d;
    logic [HALF_W:0]               out_data_q,  out_data_d;
    logic [PROD_W-1:0]             prod;

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Next-state, window shift, MAC accumulate, max tracking and output beat staging.
    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        acc_d       = acc_q;
        result_d    = result_q;
        max_d       = max_q;
        in_win_d    = in_win_q;
        w_win_d     = w_win_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        prod        = PROD_W'(in_win_q[tap_q]) * PROD_W'(w_win_q[tap_q]);

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    case (in_cmd)
                        CMD_LOAD_IN: in_win_d = {in_data, in_win_q[TAPS-1:1]};
                        CMD_LOAD_W:  w_win_d  = {in_data, w_win_q[TAPS-1:1]};
                        CMD_COMPUTE: begin
                            acc_d   = '0;
                            tap_d   = '0;
                            state_d = ST_MAC;
                        end
                        CMD_EMIT_MAX: begin
                            result_d = max_q;
                            state_d  = ST_OUT0;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_MAC: begin
                acc_d = acc_q + ACC_W'(prod);
                tap_d = tap_q + TAP_W'(1);
                if (tap_q == TAP_W'(TAPS - 1)) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                result_d = acc_q;
                if (acc_q > max_q) begin
                    max_d = acc_q;
                end
                state_d = ST_OUT0;
            end
            ST_OUT0: begin
                // First cycle in OUT0 loads the registered beat; handshakes follow.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {1'b0, result_q[HALF_W-1:0]};
                end else if (out_ready) begin
                    out_data_d = {1'b1, result_q[ACC_W-1:HALF_W]};
                    state_d    = ST_OUT1;
                end
            end
            ST_OUT1: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_data_d  = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
                out_data_d  = '0;
            end
        endcase

        // A clear overrides any max update in the same cycle; an emit-max
        // accepted this cycle has already captured the old value into result.
        if (clear_max) begin
            max_d = '0;
        end
    end

    // State and datapath registers; reset aborts any compute or pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tap_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            max_q       <= '0;
            in_win_q    <= '0;
            w_win_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            max_q       <= max_d;
            in_win_q    <= in_win_d;
            w_win_q     <= w_win_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
